reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular in-order reorder buffer between the decoder/issue stage and the register file. It allocates one entry per issued instruction and hands the allocated ROB id to the register file for renaming. It captures results from the ALU and LSB broadcast buses, serves operand lookups for the reservation station and LSB, and retires entries in program order. Each retirement produces a one-cycle commit pulse to the register file, or to the LSB for stores.

## Interface
- ROB_SIZE, 16, number of entries (power of two)
- ROB_ID_W, 4, log2(ROB_SIZE)
- REG_IDX_W, 5, architectural register index width
- DATA_W, 32, data width

- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-low reset
- rdy  input  1  global enable; low = freeze all state
- ID_issue_valid  input  1  decoder presents an instruction this cycle
- ID_rd_valid  input  1  instruction writes a register
- ID_rd  input  REG_IDX_W  destination register
- ID_is_store  input  1  instruction is a store
- ROB_full  output  1  count == ROB_SIZE; combinational from state
- ROB_alloc_id  output  ROB_ID_W  id the next issue receives (= tail); feeds RF renaming
- ALU_cdb_valid / ALU_cdb_ROB_id / ALU_cdb_value  input  1 / ROB_ID_W / DATA_W  ALU result broadcast
- LSB_cdb_valid / LSB_cdb_ROB_id / LSB_cdb_value  input  1 / ROB_ID_W / DATA_W  load result or store-address-ready broadcast
- Q1_ROB_id, Q2_ROB_id  input  ROB_ID_W  operand lookup ids
- Q1_ready, Q2_ready  output  1  entry is busy and its result is ready (combinational)
- Q1_value, Q2_value  output  DATA_W  entry value (combinational; valid when ready)
- RF_commit_valid  output  1  one-cycle register write pulse
- RF_commit_rd  output  REG_IDX_W  register to write
- RF_commit_value  output  DATA_W  value to write
- RF_commit_ROB_id  output  ROB_ID_W  id of the retiring entry; RF clears rename only if it matches
- LSB_store_commit  output  1  one-cycle pulse: head store may write memory
- LSB_store_ROB_id  output  ROB_ID_W  id of the committed store

## Operation
- Per-entry state: busy, ready, rd_valid, rd, is_store, value. Pointers head, tail (ROB_ID_W, wrap modulo ROB_SIZE). Counter count (ROB_ID_W+1 bits).
- **Issue:** on a clk edge with rdy, ID_issue_valid and !ROB_full:
  - entry[tail] ← busy=1, ready=0, fields from ID.
  - tail ← tail+1; count increments.
  - Issue while full is dropped; the decoder must stall on ROB_full.
- **Writeback:** on a clk edge with rdy and a CDB valid whose entry is busy: set ready=1 and value=cdb_value.
  - A CDB hitting a non-busy entry is ignored.
  - If both CDBs carry the same id, the ALU wins.
  - Different ids are both written in the same cycle.
- **Commit:** on a clk edge with rdy, when entry[head] is busy and ready (registered state, i.e. ready before this edge):
  - busy ← 0; head ← head+1; count decrements.
  - Non-store with rd_valid and rd≠0: RF_commit_valid=1 with rd, value and id.
  - Non-store with rd=0 or !rd_valid: retires silently.
  - Store: LSB_store_commit=1 with the id.
  - At most one commit per cycle.
- Simultaneous issue and commit: count is unchanged; both take effect.
- Issue into the slot committed in the same cycle is possible only when the ROB is full before the edge; full blocks issue, so this case does not arise.
- Lookup outputs reflect registered state only. A CDB in the same cycle is not bypassed; the RS/LSB snoop the CDB themselves.
- rdy low: no state change; commit pulse outputs are driven to 0.

## Timing
- **Reset (rst=0, asynchronous):**
  - head=tail=count=0; all busy=0.
  - RF_commit_valid=0, RF_commit_rd=0, RF_commit_value=0, RF_commit_ROB_id=0.
  - LSB_store_commit=0, LSB_store_ROB_id=0.
  - ROB_full=0, ROB_alloc_id=0, Q*_ready=0.
- Reset mid-operation discards every entry. No commit pulse is emitted on release.
- Commit outputs are registered and valid for exactly the cycle after the retiring edge.
- Minimum latency: issue at edge N, CDB at edge N+1, commit edge N+2, RF_commit_valid high during cycle N+2→N+3.
- Full/empty: ROB_full=1 at count==16. Empty (count==0) never commits. Wrap from id 15 to 0 is seamless.
- Throughput: sustained one issue and one commit per cycle.

## Test plan
- **Reset:** hold rst=0 mid-stream with 5 busy entries -> all outputs 0, count 0; after release the first issue gets ROB_alloc_id=0.
- **In-order commit:** issue rd=3, rd=4 (ids 0, 1); CDB id1=0x22, then id0=0x11 -> commits id0 (x3=0x11), then id1 (x4=0x22) on consecutive cycles.
- **Full/wrap:** issue 16 instructions -> ROB_full=1 and a 17th issue is ignored. Retire 1 and issue 1 -> new entry gets id 0, tail wraps, ROB_full returns to 1.
- **Simultaneous CDBs:** ALU and LSB both target id 2 with 0xA / 0xB -> value 0xA. Distinct ids 2 and 3 -> both ready next cycle.
- **Store and x0:** store at head, LSB_cdb id 0 -> LSB_store_commit=1 with id 0 and RF_commit_valid=0. A commit with rd=0 produces no pulse.
- **Query/rdy:** Q1 on a ready id returns its value. rdy=0 for 3 cycles with a ready head -> no commit until rdy=1.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Bundle of the decoder, CDB, operand-lookup and commit signals around the reorder buffer.
// The ROB binds the slave modport; the surrounding pipeline binds the master modport.
interface reorder_buffer_if #(
  parameter int ROB_ID_W  = 4,
  parameter int REG_IDX_W = 5,
  parameter int DATA_W    = 32
);
  // Issue: an instruction is taken on a rising edge where rdy && ID_issue_valid && !ROB_full.
  // ROB_full is the inverted ready, so the decoder holds its instruction while it is high.
  // The CDBs and commit pulses carry no back-pressure.
  logic                 ID_issue_valid;
  logic                 ID_rd_valid;
  logic [REG_IDX_W-1:0] ID_rd;
  logic                 ID_is_store;
  logic                 ROB_full;
  logic [ROB_ID_W-1:0]  ROB_alloc_id;

  logic                 ALU_cdb_valid;
  logic [ROB_ID_W-1:0]  ALU_cdb_ROB_id;
  logic [DATA_W-1:0]    ALU_cdb_value;
  logic                 LSB_cdb_valid;
  logic [ROB_ID_W-1:0]  LSB_cdb_ROB_id;
  logic [DATA_W-1:0]    LSB_cdb_value;

  logic [ROB_ID_W-1:0]  Q1_ROB_id;
  logic [ROB_ID_W-1:0]  Q2_ROB_id;
  logic                 Q1_ready;
  logic                 Q2_ready;
  logic [DATA_W-1:0]    Q1_value;
  logic [DATA_W-1:0]    Q2_value;

  logic                 RF_commit_valid;
  logic [REG_IDX_W-1:0] RF_commit_rd;
  logic [DATA_W-1:0]    RF_commit_value;
  logic [ROB_ID_W-1:0]  RF_commit_ROB_id;
  logic                 LSB_store_commit;
  logic [ROB_ID_W-1:0]  LSB_store_ROB_id;

  // Occupancy, exported for observation only.
  logic [ROB_ID_W:0]    dbg_count;

  modport slave (
    input  ID_issue_valid, ID_rd_valid, ID_rd, ID_is_store,
    input  ALU_cdb_valid, ALU_cdb_ROB_id, ALU_cdb_value,
    input  LSB_cdb_valid, LSB_cdb_ROB_id, LSB_cdb_value,
    input  Q1_ROB_id, Q2_ROB_id,
    output ROB_full, ROB_alloc_id,
    output Q1_ready, Q2_ready, Q1_value, Q2_value,
    output RF_commit_valid, RF_commit_rd, RF_commit_value, RF_commit_ROB_id,
    output LSB_store_commit, LSB_store_ROB_id,
    output dbg_count
  );

  modport master (
    output ID_issue_valid, ID_rd_valid, ID_rd, ID_is_store,
    output ALU_cdb_valid, ALU_cdb_ROB_id, ALU_cdb_value,
    output LSB_cdb_valid, LSB_cdb_ROB_id, LSB_cdb_value,
    output Q1_ROB_id, Q2_ROB_id,
    input  ROB_full, ROB_alloc_id,
    input  Q1_ready, Q2_ready, Q1_value, Q2_value,
    input  RF_commit_valid, RF_commit_rd, RF_commit_value, RF_commit_ROB_id,
    input  LSB_store_commit, LSB_store_ROB_id,
    input  dbg_count
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, captures CDB results,
// serves operand lookups and retires one entry per cycle from head.
module reorder_buffer #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_ID_W  = 4,
  parameter int REG_IDX_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  reorder_buffer_if.slave  rob
);
  localparam int CNT_W = ROB_ID_W + 1;

  logic [ROB_SIZE-1:0]  busy_q;
  logic [ROB_SIZE-1:0]  ready_q;
  logic [ROB_SIZE-1:0]  rd_valid_q;
  logic [ROB_SIZE-1:0]  is_store_q;
  logic [REG_IDX_W-1:0] rd_q    [ROB_SIZE];
  logic [DATA_W-1:0]    value_q [ROB_SIZE];

  logic [ROB_ID_W-1:0]  head_q;
  logic [ROB_ID_W-1:0]  tail_q;
  logic [CNT_W-1:0]     count_q;

  logic                 rf_valid_q;
  logic [REG_IDX_W-1:0] rf_rd_q;
  logic [DATA_W-1:0]    rf_value_q;
  logic [ROB_ID_W-1:0]  rf_id_q;
  logic                 st_commit_q;
  logic [ROB_ID_W-1:0]  st_id_q;

  logic full;
  logic issue_fire;
  logic head_done;
  logic commit_fire;
  logic commit_to_rf;
  logic commit_store;
  logic same_cdb_id;
  logic alu_hit;
  logic lsb_hit;

  assign full         = (count_q == CNT_W'(ROB_SIZE));
  assign issue_fire   = rdy & rob.ID_issue_valid & ~full;

  // Retirement looks only at registered state: a result arriving this edge retires next edge.
  assign head_done    = busy_q[head_q] & ready_q[head_q];
  assign commit_fire  = rdy & head_done;
  assign commit_store = commit_fire & is_store_q[head_q];
  assign commit_to_rf = commit_fire & ~is_store_q[head_q] & rd_valid_q[head_q]
                        & (rd_q[head_q] != '0);

  // Results for entries that are not in flight are stale and dropped; ALU wins a tie.
  assign same_cdb_id  = rob.ALU_cdb_valid & (rob.ALU_cdb_ROB_id == rob.LSB_cdb_ROB_id);
  assign alu_hit      = rdy & rob.ALU_cdb_valid & busy_q[rob.ALU_cdb_ROB_id];
  assign lsb_hit      = rdy & rob.LSB_cdb_valid & busy_q[rob.LSB_cdb_ROB_id] & ~same_cdb_id;

  // Entry storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      ready_q    <= '0;
      rd_valid_q <= '0;
      is_store_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
    end else begin
      if (lsb_hit) begin
        ready_q[rob.LSB_cdb_ROB_id] <= 1'b1;
        value_q[rob.LSB_cdb_ROB_id] <= rob.LSB_cdb_value;
      end
      if (alu_hit) begin
        ready_q[rob.ALU_cdb_ROB_id] <= 1'b1;
        value_q[rob.ALU_cdb_ROB_id] <= rob.ALU_cdb_value;
      end
      if (commit_fire) begin
        busy_q[head_q] <= 1'b0;
      end
      // Tail is never busy when issue fires, so it cannot collide with a CDB write or a commit.
      if (issue_fire) begin
        busy_q[tail_q]     <= 1'b1;
        ready_q[tail_q]    <= 1'b0;
        rd_valid_q[tail_q] <= rob.ID_rd_valid;
        rd_q[tail_q]       <= rob.ID_rd;
        is_store_q[tail_q] <= rob.ID_is_store;
      end
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (commit_fire) begin
        head_q <= head_q + ROB_ID_W'(1);
      end
      if (issue_fire) begin
        tail_q <= tail_q + ROB_ID_W'(1);
      end
      case ({issue_fire, commit_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Commit pulses: registered, high only in the cycle after the retiring edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_valid_q  <= 1'b0;
      rf_rd_q     <= '0;
      rf_value_q  <= '0;
      rf_id_q     <= '0;
      st_commit_q <= 1'b0;
      st_id_q     <= '0;
    end else begin
      rf_valid_q  <= commit_to_rf;
      st_commit_q <= commit_store;
      if (commit_to_rf) begin
        rf_rd_q    <= rd_q[head_q];
        rf_value_q <= value_q[head_q];
        rf_id_q    <= head_q;
      end
      if (commit_store) begin
        st_id_q <= head_q;
      end
    end
  end

  assign rob.ROB_full         = full;
  assign rob.ROB_alloc_id     = tail_q;
  assign rob.dbg_count        = count_q;

  assign rob.Q1_ready         = busy_q[rob.Q1_ROB_id] & ready_q[rob.Q1_ROB_id];
  assign rob.Q2_ready         = busy_q[rob.Q2_ROB_id] & ready_q[rob.Q2_ROB_id];
  assign rob.Q1_value         = value_q[rob.Q1_ROB_id];
  assign rob.Q2_value         = value_q[rob.Q2_ROB_id];

  assign rob.RF_commit_valid  = rf_valid_q;
  assign rob.RF_commit_rd     = rf_rd_q;
  assign rob.RF_commit_value  = rf_value_q;
  assign rob.RF_commit_ROB_id = rf_id_q;
  assign rob.LSB_store_commit = st_commit_q;
  assign rob.LSB_store_ROB_id = st_id_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios followed by random traffic, all checked
// against a program-order queue model of the buffer.
module tb_reorder_buffer;
  localparam int ROB_SIZE  = 16;
  localparam int ROB_ID_W  = 4;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int SB_W      = ROB_ID_W + REG_IDX_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  reorder_buffer_if #(.ROB_ID_W(ROB_ID_W), .REG_IDX_W(REG_IDX_W), .DATA_W(DATA_W)) rob_if ();

  reorder_buffer #(
    .ROB_SIZE(ROB_SIZE), .ROB_ID_W(ROB_ID_W), .REG_IDX_W(REG_IDX_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .rob(rob_if)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [ROB_ID_W-1:0]  id;
    logic                 rd_valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 st;
    logic                 done;
    logic [DATA_W-1:0]    val;
  } ent_t;

  ent_t                mq[$];      // in-flight instructions, oldest first
  logic [ROB_ID_W-1:0] m_next_id;
  logic                e_rf_valid;
  logic                e_st;
  logic [ROB_ID_W-1:0] e_st_id;
  logic [SB_W-1:0]     exp_q[$];   // expected register commits {id, rd, value}

  function automatic void model_wb(input logic [ROB_ID_W-1:0] id, input logic [DATA_W-1:0] v);
    foreach (mq[i]) begin
      if (mq[i].id == id) begin
        mq[i].done = 1'b1;
        mq[i].val  = v;
      end
    end
  endfunction

  function automatic void lookup(input logic [ROB_ID_W-1:0] id, output logic r,
                                 output logic [DATA_W-1:0] v);
    r = 1'b0;
    v = '0;
    foreach (mq[i]) begin
      if (mq[i].id == id && mq[i].done) begin
        r = 1'b1;
        v = mq[i].val;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic              r;
    logic [DATA_W-1:0] v;
    logic [SB_W-1:0]   got;
    chk("full", 64'(rob_if.ROB_full), 64'(mq.size() == ROB_SIZE));
    chk("alloc_id", 64'(rob_if.ROB_alloc_id), 64'(m_next_id));
    chk("count", 64'(rob_if.dbg_count), 64'(mq.size()));
    chk("rf_valid", 64'(rob_if.RF_commit_valid), 64'(e_rf_valid));
    chk("st_commit", 64'(rob_if.LSB_store_commit), 64'(e_st));
    if (e_st) chk("st_id", 64'(rob_if.LSB_store_ROB_id), 64'(e_st_id));
    if (rob_if.RF_commit_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_depth", 64'(exp_q.size()), 64'(1));
      end else begin
        got = {rob_if.RF_commit_ROB_id, rob_if.RF_commit_rd, rob_if.RF_commit_value};
        chk("rf_commit", 64'(got), 64'(exp_q.pop_front()));
      end
    end
    lookup(rob_if.Q1_ROB_id, r, v);
    chk("q1_ready", 64'(rob_if.Q1_ready), 64'(r));
    if (r) chk("q1_value", 64'(rob_if.Q1_value), 64'(v));
    lookup(rob_if.Q2_ROB_id, r, v);
    chk("q2_ready", 64'(rob_if.Q2_ready), 64'(r));
    if (r) chk("q2_value", 64'(rob_if.Q2_value), 64'(v));
  endtask

  // One clock: advance the model from the inputs now applied, then compare after the edge.
  task automatic tick();
    bit   can_issue;
    bit   do_commit;
    ent_t e;
    ent_t ni;
    can_issue  = (mq.size() < ROB_SIZE);
    do_commit  = rdy && (mq.size() > 0) && mq[0].done;
    e_rf_valid = 1'b0;
    e_st       = 1'b0;
    if (do_commit) begin
      e = mq[0];
      if (e.st) begin
        e_st    = 1'b1;
        e_st_id = e.id;
      end else if (e.rd_valid && e.rd != '0) begin
        e_rf_valid = 1'b1;
        exp_q.push_back({e.id, e.rd, e.val});
      end
    end
    if (rdy) begin
      if (rob_if.LSB_cdb_valid) model_wb(rob_if.LSB_cdb_ROB_id, rob_if.LSB_cdb_value);
      if (rob_if.ALU_cdb_valid) model_wb(rob_if.ALU_cdb_ROB_id, rob_if.ALU_cdb_value);
    end
    if (do_commit) void'(mq.pop_front());
    if (rdy && rob_if.ID_issue_valid && can_issue) begin
      ni.id       = m_next_id;
      ni.rd_valid = rob_if.ID_rd_valid;
      ni.rd       = rob_if.ID_rd;
      ni.st       = rob_if.ID_is_store;
      ni.done     = 1'b0;
      ni.val      = '0;
      mq.push_back(ni);
      m_next_id = m_next_id + ROB_ID_W'(1);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rob_if.ID_issue_valid = 1'b0;
    rob_if.ID_rd_valid    = 1'b0;
    rob_if.ID_rd          = '0;
    rob_if.ID_is_store    = 1'b0;
    rob_if.ALU_cdb_valid  = 1'b0;
    rob_if.ALU_cdb_ROB_id = '0;
    rob_if.ALU_cdb_value  = '0;
    rob_if.LSB_cdb_valid  = 1'b0;
    rob_if.LSB_cdb_ROB_id = '0;
    rob_if.LSB_cdb_value  = '0;
  endtask

  task automatic drive_issue(input logic v, input logic rdv, input logic [REG_IDX_W-1:0] rd,
                             input logic st);
    rob_if.ID_issue_valid = v;
    rob_if.ID_rd_valid    = rdv;
    rob_if.ID_rd          = rd;
    rob_if.ID_is_store    = st;
  endtask

  task automatic drive_alu(input logic v, input logic [ROB_ID_W-1:0] id, input logic [DATA_W-1:0] d);
    rob_if.ALU_cdb_valid  = v;
    rob_if.ALU_cdb_ROB_id = id;
    rob_if.ALU_cdb_value  = d;
  endtask

  task automatic drive_lsb(input logic v, input logic [ROB_ID_W-1:0] id, input logic [DATA_W-1:0] d);
    rob_if.LSB_cdb_valid  = v;
    rob_if.LSB_cdb_ROB_id = id;
    rob_if.LSB_cdb_value  = d;
  endtask

  task automatic apply_reset();
    idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    mq.delete();
    exp_q.delete();
    m_next_id  = '0;
    e_rf_valid = 1'b0;
    e_st       = 1'b0;
    chk("rst_full", 64'(rob_if.ROB_full), 64'(0));
    chk("rst_alloc", 64'(rob_if.ROB_alloc_id), 64'(0));
    chk("rst_count", 64'(rob_if.dbg_count), 64'(0));
    chk("rst_rf_valid", 64'(rob_if.RF_commit_valid), 64'(0));
    chk("rst_rf_rd", 64'(rob_if.RF_commit_rd), 64'(0));
    chk("rst_rf_value", 64'(rob_if.RF_commit_value), 64'(0));
    chk("rst_rf_id", 64'(rob_if.RF_commit_ROB_id), 64'(0));
    chk("rst_st", 64'(rob_if.LSB_store_commit), 64'(0));
    chk("rst_st_id", 64'(rob_if.LSB_store_ROB_id), 64'(0));
    chk("rst_q1", 64'(rob_if.Q1_ready), 64'(0));
    chk("rst_q2", 64'(rob_if.Q2_ready), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain(input int budget);
    idle();
    rdy = 1'b1;
    for (int i = 0; i < budget && mq.size() > 0; i++) begin
      drive_alu(1'b1, mq[0].id, $urandom);
      tick();
    end
    idle();
    tick();
    chk("drain_empty", 64'(mq.size()), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rdy = 1'b1;
    rob_if.Q1_ROB_id = '0;
    rob_if.Q2_ROB_id = '0;
    apply_reset();

    // In-order commit with out-of-order results
    drive_issue(1'b1, 1'b1, 5'd3, 1'b0); tick();
    drive_issue(1'b1, 1'b1, 5'd4, 1'b0); tick();
    idle();
    drive_alu(1'b1, 4'd1, 32'h22); tick();
    drive_alu(1'b1, 4'd0, 32'h11); tick();
    idle(); tick();
    chk("io_valid0", 64'(rob_if.RF_commit_valid), 64'(1));
    chk("io_rd0", 64'(rob_if.RF_commit_rd), 64'(3));
    chk("io_val0", 64'(rob_if.RF_commit_value), 64'(32'h11));
    chk("io_id0", 64'(rob_if.RF_commit_ROB_id), 64'(0));
    tick();
    chk("io_valid1", 64'(rob_if.RF_commit_valid), 64'(1));
    chk("io_rd1", 64'(rob_if.RF_commit_rd), 64'(4));
    chk("io_val1", 64'(rob_if.RF_commit_value), 64'(32'h22));
    chk("io_id1", 64'(rob_if.RF_commit_ROB_id), 64'(1));

    // Reset with 5 entries in flight
    for (int i = 0; i < 5; i++) begin
      drive_issue(1'b1, 1'b1, 5'($urandom_range(1, 31)), 1'b0);
      tick();
    end
    apply_reset();

    // Fill to 16, drop a 17th, retire one and wrap tail
    for (int i = 0; i < ROB_SIZE; i++) begin
      drive_issue(1'b1, 1'b1, 5'($urandom_range(1, 31)), 1'b0);
      tick();
    end
    chk("full16", 64'(rob_if.ROB_full), 64'(1));
    tick();
    chk("full17_alloc", 64'(rob_if.ROB_alloc_id), 64'(0));
    idle();
    drive_alu(1'b1, 4'd0, $urandom); tick();
    idle(); tick();
    chk("retire_unfull", 64'(rob_if.ROB_full), 64'(0));
    drive_issue(1'b1, 1'b1, 5'd7, 1'b0); tick();
    idle();
    chk("wrap_full", 64'(rob_if.ROB_full), 64'(1));
    chk("wrap_alloc", 64'(rob_if.ROB_alloc_id), 64'(1));

    // Simultaneous CDBs
    rob_if.Q1_ROB_id = 4'd2;
    drive_alu(1'b1, 4'd2, 32'hA);
    drive_lsb(1'b1, 4'd2, 32'hB);
    tick();
    chk("same_id_val", 64'(rob_if.Q1_value), 64'(32'hA));
    rob_if.Q1_ROB_id = 4'd3;
    rob_if.Q2_ROB_id = 4'd4;
    drive_alu(1'b1, 4'd3, 32'h33);
    drive_lsb(1'b1, 4'd4, 32'h44);
    tick();
    chk("dist_rdy3", 64'(rob_if.Q1_ready), 64'(1));
    chk("dist_rdy4", 64'(rob_if.Q2_ready), 64'(1));
    chk("dist_val4", 64'(rob_if.Q2_value), 64'(32'h44));
    drain(80);

    // Store and x0 retirement
    apply_reset();
    drive_issue(1'b1, 1'b0, 5'd0, 1'b1); tick();
    idle();
    drive_lsb(1'b1, 4'd0, $urandom); tick();
    idle(); tick();
    chk("st_pulse", 64'(rob_if.LSB_store_commit), 64'(1));
    chk("st_pulse_id", 64'(rob_if.LSB_store_ROB_id), 64'(0));
    chk("st_no_rf", 64'(rob_if.RF_commit_valid), 64'(0));
    drive_issue(1'b1, 1'b1, 5'd0, 1'b0); tick();
    drive_issue(1'b1, 1'b0, 5'd7, 1'b0);
    drive_alu(1'b1, 4'd1, $urandom); tick();
    idle();
    drive_alu(1'b1, 4'd2, $urandom); tick();
    chk("x0_silent", 64'(rob_if.RF_commit_valid), 64'(0));
    idle(); tick();
    chk("nord_silent", 64'(rob_if.RF_commit_valid), 64'(0));

    // Lookup and rdy freeze
    drive_issue(1'b1, 1'b1, 5'd9, 1'b0); tick();
    idle();
    rob_if.Q1_ROB_id = 4'd3;
    drive_alu(1'b1, 4'd3, 32'h99); tick();
    chk("q1_ready99", 64'(rob_if.Q1_ready), 64'(1));
    chk("q1_val99", 64'(rob_if.Q1_value), 64'(32'h99));
    rdy = 1'b0;
    drive_issue(1'b1, 1'b1, 5'd12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_hold", 64'(rob_if.RF_commit_valid), 64'(0));
    end
    idle();
    rdy = 1'b1;
    tick();
    chk("rdy_commit", 64'(rob_if.RF_commit_valid), 64'(1));
    chk("rdy_commit_rd", 64'(rob_if.RF_commit_rd), 64'(9));

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      drive_issue(1'($urandom_range(0, 2) != 0), 1'($urandom), 5'($urandom),
                  1'($urandom_range(0, 3) == 0));
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        drive_alu(1'($urandom), mq[$urandom_range(0, mq.size() - 1)].id, $urandom);
      else
        drive_alu(1'($urandom), 4'($urandom), $urandom);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        drive_lsb(1'($urandom), mq[$urandom_range(0, mq.size() - 1)].id, $urandom);
      else
        drive_lsb(1'($urandom), 4'($urandom), $urandom);
      rob_if.Q1_ROB_id = 4'($urandom);
      rob_if.Q2_ROB_id = 4'($urandom);
      tick();
    end
    drain(80);
    chk("sb_left", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
